// File: rtl/cascade_digit_counter_pkg.sv
// ---------------------------------------------------------------------------
// cascade_digit_counter_pkg
//   Shared constants and helpers for the cascaded multi-digit counter.
//   - Default digit width, digit count and the two alternating moduli.
//   - stage_mod(): maps a stage index to its modulus (even -> MOD_EVEN,
//     odd -> MOD_ODD), so mm:ss style chains come out as 10,6,10,6,...
//   - digit_lsb(): bit offset of a digit slice inside the packed Q/D bus.
// ---------------------------------------------------------------------------
package cascade_digit_counter_pkg;

  localparam int N_DEFAULT        = 4;
  localparam int DIGITS_DEFAULT   = 4;
  localparam int MOD_EVEN_DEFAULT = 10;
  localparam int MOD_ODD_DEFAULT  = 6;

  // Width of one digit slice on the packed buses.
  localparam int DIGIT_W = N_DEFAULT;

  // Modulus of stage idx: even stages use mod_even, odd stages mod_odd.
  function automatic int stage_mod(input int idx, input int mod_even,
                                   input int mod_odd);
    return ((idx % 2) == 0) ? mod_even : mod_odd;
  endfunction

  // Least significant bit of digit idx when each digit is n bits wide.
  function automatic int digit_lsb(input int idx, input int n);
    return idx * n;
  endfunction

endpackage

// File: rtl/cascade_digit_counter_if.sv
// ---------------------------------------------------------------------------
// cascade_digit_counter_if
//   Groups the control and data signals of the digit counter chain.
//   Signals:
//     E        count tick, one-cycle pulse from the prescaler
//     Run      1 = count, 0 = pause
//     Up       1 = count up, 0 = count down
//     Load     synchronous preset strobe
//     D        preset value, digit i in D[i*N +: N]
//     Q        registered count, digit i in Q[i*N +: N]
//     TC       combinational: every digit at its terminal value for Up
//     Zero     combinational: Q == 0
//     Rollover registered one-cycle pulse after a full-chain wrap
//
//   Handshake: there is no valid/ready pair. E is a fire-and-forget pulse;
//   it is consumed on the rising edge where it is high together with
//   Run = 1 and Load = 0, and is otherwise dropped (never queued). Load is
//   likewise a single-edge strobe that always takes effect when high.
//
//   master: the side that drives the controls (prescaler / testbench).
//   slave : the counter itself.
// ---------------------------------------------------------------------------
interface cascade_digit_counter_if
  import cascade_digit_counter_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
);

  logic                  E;
  logic                  Run;
  logic                  Up;
  logic                  Load;
  logic [DIGITS*N-1:0]   D;
  logic [DIGITS*N-1:0]   Q;
  logic                  TC;
  logic                  Zero;
  logic                  Rollover;

  modport master (
    output E, Run, Up, Load, D,
    input  Q, TC, Zero, Rollover
  );

  modport slave (
    input  E, Run, Up, Load, D,
    output Q, TC, Zero, Rollover
  );

endinterface

// File: rtl/cascade_digit_counter_digit_cell.sv
// ---------------------------------------------------------------------------
// counter_digit_cell
//   One modulo-MOD digit of the cascade. Holds an N-bit digit that only ever
//   takes values in [0, MOD-1].
//   Ports:
//     Clock     rising-edge clock
//     Resetn    synchronous active-low reset (digit -> 0)
//     load      preset strobe; wins over step
//     load_val  preset digit; values >= MOD load as 0
//     step      advance one position in the direction given by up
//     up        1 = increment with wrap MOD-1 -> 0, 0 = decrement 0 -> MOD-1
//     digit     registered digit value
//     term      combinational: digit sits at the terminal value for up
//               (MOD-1 counting up, 0 counting down)
// ---------------------------------------------------------------------------
module counter_digit_cell #(
  parameter int N   = 4,
  parameter int MOD = 10
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         step,
  input  logic         up,
  output logic [N-1:0] digit,
  output logic         term
);

  localparam logic [N-1:0] MAX_VAL = N'(MOD - 1);
  // One extra bit so MOD == 2**N still compares correctly.
  localparam logic [N:0]   MOD_W   = (N + 1)'(MOD);

  logic [N-1:0] digit_q;
  logic [N-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // Out-of-range presets would escape the modulo range forever; clamp.
      if ({1'b0, load_val} >= MOD_W) begin
        digit_d = '0;
      end else begin
        digit_d = load_val;
      end
    end else if (step) begin
      if (up) begin
        digit_d = (digit_q == MAX_VAL) ? '0 : digit_q + N'(1);
      end else begin
        digit_d = (digit_q == '0) ? MAX_VAL : digit_q - N'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign term  = up ? (digit_q == MAX_VAL) : (digit_q == '0);

endmodule

// File: rtl/cascade_digit_counter.sv
// ---------------------------------------------------------------------------
// cascade_digit_counter
//   Parametrised chain of DIGITS modulo counters for clock/timer displays.
//   Stage 0 is least significant; even stages count modulo MOD_EVEN, odd
//   stages modulo MOD_ODD. Counts up or down, supports synchronous preset.
//   Ports:
//     Clock   rising-edge clock
//     Resetn  synchronous active-low reset (Q -> 0, Rollover -> 0)
//     bus     slave side of cascade_digit_counter_if
//             (E, Run, Up, Load, D in; Q, TC, Zero, Rollover out)
//   Edge priority: reset > Load > pause (Run = 0) > count.
// ---------------------------------------------------------------------------
module cascade_digit_counter
  import cascade_digit_counter_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int DIGITS   = DIGITS_DEFAULT,
  parameter int MOD_EVEN = MOD_EVEN_DEFAULT,
  parameter int MOD_ODD  = MOD_ODD_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  cascade_digit_counter_if.slave  bus
);

  logic                 adv;
  logic [DIGITS:0]      carry;
  logic [DIGITS-1:0]    term;
  logic [DIGITS-1:0]    step;
  logic [DIGITS*N-1:0]  q;
  logic                 rollover_q;
  logic                 rollover_d;

  // Load outranks counting, so a tick coinciding with Load is discarded.
  assign adv = bus.Run & bus.E & ~bus.Load;

  // carry[i] = every stage below i is at its terminal value. Evaluated on
  // the pre-edge Q so all stages step together on the same edge.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_stage
    localparam int LSB      = digit_lsb(i, N);
    localparam int STAGE_MD = stage_mod(i, MOD_EVEN, MOD_ODD);

    assign carry[i+1] = carry[i] & term[i];
    assign step[i]    = adv & carry[i];

    counter_digit_cell #(
      .N   (N),
      .MOD (STAGE_MD)
    ) u_cell (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .load     (bus.Load),
      .load_val (bus.D[LSB +: N]),
      .step     (step[i]),
      .up       (bus.Up),
      .digit    (q[LSB +: N]),
      .term     (term[i])
    );
  end

  // The whole chain wraps exactly when it advances while every digit is
  // terminal. Load and pause force adv low, which clears the pulse.
  always_comb begin
    rollover_d = adv & carry[DIGITS];
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= rollover_d;
    end
  end

  assign bus.Q        = q;
  assign bus.TC       = carry[DIGITS];
  assign bus.Zero     = (q == '0);
  assign bus.Rollover = rollover_q;

endmodule

// File: tb/tb_cascade_digit_counter.sv
// ---------------------------------------------------------------------------
// tb_cascade_digit_counter
//   Reference model treats the chain as one mixed-radix integer in
//   [0, TOTAL-1]; counting is +/-1 modulo TOTAL. Expected Q/Rollover are
//   pushed on each rising edge and popped and compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_cascade_digit_counter;

  localparam int N      = 4;
  localparam int DIGITS = 4;
  localparam int W      = N * DIGITS;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cascade_digit_counter_if #(.N(N), .DIGITS(DIGITS)) bus ();

  cascade_digit_counter #(
    .N        (N),
    .DIGITS   (DIGITS),
    .MOD_EVEN (10),
    .MOD_ODD  (6)
  ) dut (
    .Clock  (clk),
    .Resetn (rstn),
    .bus    (bus)
  );

  int n_vec;
  int n_err;

  // ---------------- model helpers ----------------
  function automatic int mod_of(input int i);
    return ((i % 2) == 0) ? 10 : 6;
  endfunction

  function automatic int weight_of(input int i);
    int w;
    w = 1;
    for (int k = 0; k < i; k++) w = w * mod_of(k);
    return w;
  endfunction

  function automatic int total_count();
    return weight_of(DIGITS);
  endfunction

  // Preset bus -> integer, with out-of-range digits treated as 0.
  function automatic int bus_to_val(input logic [W-1:0] d);
    int v;
    int dig;
    v = 0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = int'(d[i*N +: N]);
      if (dig >= mod_of(i)) dig = 0;
      v = v + dig * weight_of(i);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] val_to_bus(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*N +: N] = N'((v / weight_of(i)) % mod_of(i));
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [W:0] exp_q[$];   // {rollover, Q} expected after each edge
  int         m_val;

  always @(posedge clk) begin
    logic m_roll;
    int   t;
    t      = total_count();
    m_roll = 1'b0;
    if (!rstn) begin
      m_val = 0;
    end else if (bus.Load) begin
      m_val = bus_to_val(bus.D);
    end else if (bus.Run && bus.E) begin
      if (bus.Up) begin
        m_roll = (m_val == t - 1);
        m_val  = (m_val + 1) % t;
      end else begin
        m_roll = (m_val == 0);
        m_val  = (m_val + t - 1) % t;
      end
    end
    exp_q.push_back({m_roll, val_to_bus(m_val)});
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W:0]   e;
    logic [W-1:0] eq;
    int           v;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: got no expectation, expected one at %0t", $time);
    end else begin
      e  = exp_q.pop_front();
      eq = e[W-1:0];
      v  = bus_to_val(eq);
      cmp("q",        bus.Q, eq);
      cmp("rollover", W'(bus.Rollover), W'(e[W]));
      cmp("zero",     W'(bus.Zero), W'(v == 0));
      cmp("tc",       W'(bus.TC),
          W'(bus.Up ? (v == total_count() - 1) : (v == 0)));
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge: drives inputs, returns at the next falling
  // edge, i.e. after exactly one rising edge has consumed them.
  task automatic apply(input logic r, input logic e, input logic run,
                       input logic up, input logic ld, input logic [W-1:0] d);
    #1;
    rstn     = r;
    bus.E    = e;
    bus.Run  = run;
    bus.Up   = up;
    bus.Load = ld;
    bus.D    = d;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic up_r;
    n_vec    = 0;
    n_err    = 0;
    rstn     = 1'b0;
    bus.E    = 1'b1;
    bus.Run  = 1'b1;
    bus.Up   = 1'b1;
    bus.Load = 1'b0;
    bus.D    = '0;
    @(negedge clk);

    // reset with ticks active
    apply(0, 1, 1, 1, 0, 16'h0000);
    apply(0, 1, 1, 1, 0, 16'h0000);
    cmp("lit_reset_q",    bus.Q, 16'h0000);
    cmp("lit_reset_roll", W'(bus.Rollover), W'(0));
    cmp("lit_reset_zero", W'(bus.Zero), W'(1));

    // load and count up across a digit boundary
    apply(1, 0, 1, 1, 1, 16'h0058);
    cmp("lit_load58", bus.Q, 16'h0058);
    apply(1, 1, 1, 1, 0, 16'h0000);
    cmp("lit_up59", bus.Q, 16'h0059);
    apply(1, 1, 1, 1, 0, 16'h0000);
    cmp("lit_up100", bus.Q, 16'h0100);
    cmp("lit_up100_roll", W'(bus.Rollover), W'(0));

    // full-chain wrap upward
    apply(1, 0, 1, 1, 1, 16'h5959);
    cmp("lit_tc_5959", W'(bus.TC), W'(1));
    apply(1, 1, 1, 1, 0, 16'h0000);
    cmp("lit_wrap_q",    bus.Q, 16'h0000);
    cmp("lit_wrap_roll", W'(bus.Rollover), W'(1));
    apply(1, 0, 1, 1, 0, 16'h0000);
    cmp("lit_wrap_roll_clr", W'(bus.Rollover), W'(0));

    // full-chain wrap downward, then borrow across a boundary
    apply(1, 1, 1, 0, 0, 16'h0000);
    cmp("lit_down_wrap_q",    bus.Q, 16'h5959);
    cmp("lit_down_wrap_roll", W'(bus.Rollover), W'(1));
    apply(1, 0, 1, 0, 1, 16'h0100);
    apply(1, 1, 1, 0, 0, 16'h0000);
    cmp("lit_down_59", bus.Q, 16'h0059);

    // pause drops ticks
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 0, 0, 0, 16'h0000);
      cmp("lit_pause", bus.Q, 16'h0059);
    end
    apply(1, 0, 0, 1, 1, 16'h1234);
    cmp("lit_load_paused", bus.Q, 16'h1234);

    // clamp of out-of-range digits, load beats tick
    apply(1, 0, 1, 1, 1, 16'h7A12);
    cmp("lit_clamp", bus.Q, 16'h0012);
    apply(1, 1, 1, 1, 1, 16'h0003);
    cmp("lit_load_vs_e", bus.Q, 16'h0003);

    // reset in the middle of counting
    apply(1, 1, 1, 1, 0, 16'h0000);
    apply(0, 1, 1, 1, 0, 16'h0000);
    cmp("lit_mid_reset", bus.Q, 16'h0000);

    // randomized phase
    up_r = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] d;
      if ($urandom_range(0, 99) == 0) up_r = ~up_r;
      d = W'($urandom);
      // bias some presets to near-terminal values to provoke chain wraps
      if ($urandom_range(0, 1) == 0) d = up_r ? 16'h5957 : 16'h0002;
      apply(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 7) != 0),
            up_r,
            ($urandom_range(0, 59) == 0),
            d);
    end

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cascade_digit_counter.md
Name: cascade_digit_counter

Overview:
- Parametrised multi-digit modulo counter chain for the lab clock/timer displays (mm:ss, hh:mm and similar formats).
- Generalises the single cascaded seconds digit: configurable digit count and width, alternating moduli, up/down counting, synchronous preset load, and a correctly aligned chain carry.
- Sits between the tick prescaler (E) and the 7-segment decoders, one N-bit field per HEX digit.

Parameters:
- N, 4, bits per digit.
- DIGITS, 4, number of cascaded digits; stage 0 is the least significant.
- MOD_EVEN, 10, modulus of stages 0, 2, 4, …; 2 ≤ MOD_EVEN ≤ 2^N.
- MOD_ODD, 6, modulus of stages 1, 3, 5, …; 2 ≤ MOD_ODD ≤ 2^N.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  synchronous active-low reset.
- E  in  1  count tick, one-cycle pulse from the prescaler.
- Run  in  1  1 = count, 0 = pause (digits hold).
- Up  in  1  1 = count up, 0 = count down.
- Load  in  1  synchronous preset strobe.
- D  in  DIGITS*N  preset value, digit i in D[i*N +: N].
- Q  out  DIGITS*N  registered count, digit i in Q[i*N +: N].
- TC  out  1  combinational: all digits at terminal value for the current Up.
- Zero  out  1  combinational: Q == 0.
- Rollover  out  1  registered one-cycle pulse after a full-chain wrap.

Behaviour:
- Priority per rising edge: Resetn = 0 > Load > Run = 0 > count.
- Reset: Q = 0, Rollover = 0. Reset applied mid-count takes effect at the next edge.
- Load (Resetn = 1): Q ← D digit-wise and Rollover ← 0. Load ignores Run and E.
  - Any loaded digit ≥ its stage modulus loads 0; other digits load unaltered.
- Pause (Run = 0, Load = 0): Q holds and Rollover ← 0. E pulses during pause are dropped, not queued.
- Advance: adv = Run & E & ~Load.
- Terminal value per digit: MOD−1 when Up = 1, 0 when Up = 0.
- Stage i steps on an edge when adv = 1 and all stages j < i sit at their terminal value. Stage 0 steps on every adv.
- Step up: if digit = MOD−1 then 0, else +1. Step down: if digit = 0 then MOD−1, else −1.
- Carry is evaluated from Q before the edge. All stages update on the same edge: zero latency from E to Q, no look-ahead trick.
- TC = AND over stages of (digit == terminal). It is combinational and usable as E/Run qualifier when cascading a second chain.
- Rollover ← adv & TC, so it is high for exactly the cycle after the edge on which the whole chain wrapped. Otherwise Rollover ← 0.
- Up may change on any cycle and takes effect at the next edge. Each digit wraps within [0, MOD−1] only.
- Arithmetic is per digit, N bits wide, with no binary overflow. A digit never leaves [0, MOD−1] once reset or loaded.
- Zero = (Q == 0), combinational, independent of Up.

Decomposition:
- Shared package/include holds:
  - default N, MOD_EVEN, MOD_ODD;
  - the per-stage modulus function (index parity → modulus);
  - the digit-slice width constant.
- One sub-module, counter_digit_cell, instantiated DIGITS times in a generate loop.
  - Parameters: N, MOD.
  - Inputs: Clock, Resetn, load, load value, step, Up.
  - Outputs: digit, terminal flag.
- The top level handles the carry AND-chain, TC, Zero and the Rollover register.

Test Plan (DIGITS = 4, defaults, hex-per-digit notation):
- Resetn = 0 for 2 cycles with E = 1, Run = 1 → Q = 0x0000, Rollover = 0, Zero = 1.
- Load D = 0x0058, Up = 1, two E pulses → Q = 0x0059, then 0x0100; Rollover stays 0.
- Load 0x5959, Up = 1, one E pulse → Q = 0x0000 on that edge, Rollover = 1 for exactly the next cycle. TC = 1 before the edge.
- Up = 0 from Q = 0x0000, one E → Q = 0x5959 with a Rollover pulse. From 0x0100, one E → 0x0059.
- Run = 0 with E = 1 for 5 cycles → Q unchanged. Load with Run = 0 and D = 0x1234 → Q = 0x1234.
- Load D = 0x7A12 → Q = 0x0012 (clamp). Load and E in the same cycle with D = 0x0003 → Q = 0x0003, no step.
